seq_event_display: RTL and testbench

Downstream display stage for the serial sequence detector. Consumes the detector's `z` flag and shows the running detection count on a single 7-segment digit. The decimal point acts as a "just detected" lamp held for a programmable time. Until the first detection, or after a clear, the digit shows a dash. Drives the `uo_out` segment bus directly.

---
 rtl/seq_disp_pkg.sv | 22 ++
 rtl/seq_event_display_seg7.sv | 20 ++
 rtl/seq_event_display.sv | 87 ++++++++
 tb/tb_seq_event_display.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_disp_pkg.sv
// Shared types and constants for the sequence-event display stage.
// Optional feature macro: SEQDISP_HEX_EN (hex digits A..F, wrap at 16).
package seq_disp_pkg;

    typedef enum logic [1:0] {
        DASH = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         SEG_DP    = 7;

    // Digit patterns, segments a..g on bits [6:0]; element 15 listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77,  // F E d C b A
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66,  // 9 8 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F                 // 3 2 1 0
    };

endpackage

// File: rtl/seq_event_display_seg7.sv
// Combinational 4-bit value to 7-segment pattern.
// With SEQDISP_HEX_EN defined, 10..15 show A b C d E F; otherwise they show the dash.
module seg7_hex_decoder
    import seq_disp_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_pattern
);

    // Table lookup, with out-of-range decimal codes mapped to the dash.
    always_comb begin
        o_pattern = SEG_TABLE[i_value];
`ifndef SEQDISP_HEX_EN
        if (i_value > 4'd9) begin
            o_pattern = SEG_DASH[6:0];
        end
`endif
    end

endmodule

// File: rtl/seq_event_display.sv
// Display stage for the serial sequence detector: counts rising edges of det,
// shows the count on one 7-segment digit and lights dp for HOLD_CYCLES after
// each detection. Optional macro: SEQDISP_HEX_EN (count modulo 16, hex digits).
module seq_event_display
    import seq_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             det,
    input  logic             clr,
    output logic [7:0]       seg_out,
    output logic [CNT_W-1:0] count_out,
    output logic             ovf
);

    localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
`ifdef SEQDISP_HEX_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(15);
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(9);
`endif

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_det_q;

    logic             w_event;
    logic             w_wrap;
    logic [CNT_W-1:0] w_count_nxt;
    logic [3:0]       w_dec_in;
    logic [6:0]       w_pattern;

    assign w_event     = det & ~r_det_q & ena;
    assign w_wrap      = (count_out == CNT_LAST);
    assign w_count_nxt = w_wrap ? '0 : count_out + CNT_W'(1);
    assign w_dec_in    = w_event ? w_count_nxt[3:0] : count_out[3:0];

    seg7_hex_decoder u_dec (
        .i_value   (w_dec_in),
        .o_pattern (w_pattern)
    );

    // Edge-detect register keeps sampling det even while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_q <= 1'b0;
        end else begin
            r_det_q <= det;
        end
    end

    // Display FSM with counter, hold timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DASH;
            r_timer   <= '0;
            count_out <= '0;
            ovf       <= 1'b0;
            seg_out   <= SEG_DASH;
        end else if (ena) begin
            ovf <= 1'b0;
            if (clr) begin
                r_state   <= DASH;
                r_timer   <= '0;
                count_out <= '0;
                seg_out   <= SEG_DASH;
            end else if (w_event) begin
                r_state   <= HOLD;
                r_timer   <= TMR_W'(HOLD_CYCLES);
                count_out <= w_count_nxt;
                ovf       <= w_wrap;
                seg_out   <= {1'b1, w_pattern};
            end else if (r_state == HOLD) begin
                r_timer <= r_timer - TMR_W'(1);
                if (r_timer == TMR_W'(1)) begin
                    r_state <= SHOW;
                    seg_out <= {1'b0, w_pattern};
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_event_display.sv
// Randomized self-checking bench for seq_event_display against a
// count/remaining-time reference model.
module tb_seq_event_display;

    localparam int HOLD = 5;
`ifdef SEQDISP_HEX_EN
    localparam int MODULUS = 16;
`else
    localparam int MODULUS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       ena;
    logic       det;
    logic       clr;
    logic [7:0] seg_out;
    logic [3:0] count_out;
    logic       ovf;

    seq_event_display #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .det       (det),
        .clr       (clr),
        .seg_out   (seg_out),
        .count_out (count_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_count;
    int m_remain;
    bit m_dash;
    bit m_ovf;
    bit m_prev_det;
    logic [7:0] pat [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] model_seg();
        if (m_dash) return 8'h40;
        return pat[m_count] | ((m_remain > 0) ? 8'h80 : 8'h00);
    endfunction

    task automatic model_reset();
        m_count = 0; m_remain = 0; m_dash = 1; m_ovf = 0; m_prev_det = 0;
    endtask

    task automatic model_edge(input bit d, input bit e, input bit c);
        bit ev;
        ev = d && !m_prev_det && e;
        if (e) begin
            if (c) begin
                m_dash = 1; m_count = 0; m_remain = 0; m_ovf = 0;
            end else if (ev) begin
                m_count  = (m_count + 1) % MODULUS;
                m_ovf    = (m_count == 0);
                m_dash   = 0;
                m_remain = HOLD;
            end else begin
                if (m_remain > 0) m_remain--;
                m_ovf = 0;
            end
        end
        m_prev_det = d;
    endtask

    // One clock: drive inputs at negedge, clock, then compare 1 time unit later.
    task automatic step(input bit d, input bit e, input bit c);
        @(negedge clk);
        det = d; ena = e; clr = c;
        @(posedge clk);
        model_edge(d, e, c);
        #1;
        check("seg_out", 32'(seg_out), 32'(model_seg()));
        check("count_out", 32'(count_out), 32'(m_count));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic pulse();
        step(1, 1, 0);
        step(0, 1, 0);
    endtask

    initial begin
        int saved;
        rst = 1; ena = 0; det = 0; clr = 0;
        model_reset();
        #23;
        check("reset_seg", 32'(seg_out), 32'h40);
        check("reset_count", 32'(count_out), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        rst = 0;

        // Idle with det low
        for (int i = 0; i < 20; i++) step(0, 1, 0);

        // Single pulse: dp on for HOLD cycles
        step(1, 1, 0);
        check("pulse_seg", 32'(seg_out), 32'h86);
        check("pulse_count", 32'(count_out), 32'h1);
        for (int i = 0; i < HOLD + 3; i++) step(0, 1, 0);
        check("after_hold_seg", 32'(seg_out), 32'h06);

        // Level held high counts once
        for (int i = 0; i < 50; i++) step(1, 1, 0);
        check("level_count", 32'(count_out), 32'h2);
        step(0, 1, 0);

        // Wrap test from a clean count
        step(0, 1, 1);
`ifdef SEQDISP_HEX_EN
        for (int i = 0; i < 12; i++) pulse();
        check("hex_count", 32'(count_out), 32'hC);
        check("hex_seg", 32'(seg_out[6:0]), 32'h39);
        for (int i = 0; i < 4; i++) pulse();
        check("hex_wrap_count", 32'(count_out), 32'h0);
`else
        for (int i = 0; i < 9; i++) pulse();
        check("dec_nine", 32'(count_out), 32'h9);
        step(1, 1, 0);
        check("dec_wrap_count", 32'(count_out), 32'h0);
        check("dec_wrap_ovf", 32'(ovf), 32'h1);
        check("dec_wrap_seg", 32'(seg_out), 32'hBF);
        step(0, 1, 0);
        check("dec_ovf_pulse", 32'(ovf), 32'h0);
`endif

        // clr together with a det rising edge
        step(1, 1, 1);
        check("clr_ev_seg", 32'(seg_out), 32'h40);
        check("clr_ev_count", 32'(count_out), 32'h0);
        check("clr_ev_ovf", 32'(ovf), 32'h0);
        step(0, 1, 0);

        // ena low while det toggles, then raise ena with det high
        pulse();
        saved = m_count;
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
        step(1, 1, 0);
        check("ena_no_event", 32'(count_out), 32'(saved));
        step(0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit d, e, c;
            d = ($urandom_range(0, 99) < 35) ? ~det : det;
            e = ($urandom_range(0, 99) < 88);
            c = e && ($urandom_range(0, 99) < 2);
            step(d, e, c);
        end

        // Asynchronous reset in the middle of HOLD
        step(0, 1, 0);
        step(1, 1, 0);
        check("pre_rst_dp", 32'(seg_out[7]), 32'h1);
        #2;
        rst = 1;
        #1;
        check("async_rst_seg", 32'(seg_out), 32'h40);
        check("async_rst_count", 32'(count_out), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0; det = 0;
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        pulse();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
